seq_alu_mc: RTL and testbench



---
 rtl/seq_alu_mc.sv | 111 +++++++++++
 tb/tb_seq_alu_mc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_mc.sv
// Multi-cycle ALU: AND/OR in one cycle, logical shifts one bit per clock, with a valid/ready handshake on each side.
// Latency: 1 cycle for AND/OR and for zero-length shifts, else 1+n (n saturated at WIDTH); the result is held while out_ready is low.
module seq_alu_mc #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  localparam logic [WIDTH-1:0] B_SAT   = WIDTH'(WIDTH);
  localparam logic [CNTW-1:0]  CNT_SAT = CNTW'(WIDTH);
  localparam logic [CNTW-1:0]  CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [CNTW-1:0]  shamt;

  // Any amount >= WIDTH clears the operand, so WIDTH single-bit shifts suffice.
  assign shamt = (b >= B_SAT) ? CNT_SAT : b[CNTW-1:0];

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = op;
          case (op)
            OP_AND: begin
              d_d     = a & b;
              state_d = ST_DONE;
            end
            OP_OR: begin
              d_d     = a | b;
              state_d = ST_DONE;
            end
            default: begin
              d_d     = a;
              cnt_d   = shamt;
              state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
            end
          endcase
        end
      end
      ST_SHIFT: begin
        d_d   = (op_q == OP_SHR) ? {1'b0, d_q[WIDTH-1:1]} : {d_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      cnt_q   <= '0;
      op_q    <= OP_AND;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT);
  assign d         = d_q;

  a_state_legal: assert property (@(posedge clk) state_q != 2'd3);

  a_hold_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(d)));

  a_shl_code_unused_by_shift_dir: assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> (op_q == OP_SHL || op_q == OP_SHR));

endmodule

// File: tb/tb_seq_alu_mc.sv
// Bench for seq_alu_mc: directed and random 8-bit ops, a reset-mid-shift case, and an exhaustive 4-bit sweep
// against a plain-arithmetic model of the result and of the cycle counts.
module tb_seq_alu_mc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] op_r = 2'b00;
  logic [7:0] a_r = 8'h00;
  logic [7:0] b_r = 8'h00;

  logic       iv8 = 1'b0, ordy8 = 1'b0;
  logic       ir8, ov8, bz8;
  logic [7:0] d8;

  logic       iv4 = 1'b0, ordy4 = 1'b0;
  logic       ir4, ov4, bz4;
  logic [3:0] d4;

  bit sel4 = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op_r), .a(a_r), .b(b_r),
    .out_valid(ov8), .out_ready(ordy8), .d(d8), .busy(bz8)
  );

  seq_alu_mc #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .op(op_r), .a(a_r[3:0]), .b(b_r[3:0]),
    .out_valid(ov4), .out_ready(ordy4), .d(d4), .busy(bz4)
  );

  function automatic int unsigned o_d();
    return sel4 ? 32'(d4) : 32'(d8);
  endfunction
  function automatic int unsigned o_ov();
    return sel4 ? 32'(ov4) : 32'(ov8);
  endfunction
  function automatic int unsigned o_ir();
    return sel4 ? 32'(ir4) : 32'(ir8);
  endfunction
  function automatic int unsigned o_bz();
    return sel4 ? 32'(bz4) : 32'(bz8);
  endfunction

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result of op on w-bit operands, from the arithmetic definition.
  function automatic int unsigned golden(input int w, input int unsigned op, input int unsigned a,
                                         input int unsigned b);
    int unsigned mask;
    mask = (32'd1 << w) - 1;
    case (op)
      0: return a & b;
      2: return a | b;
      1: return (b >= 32'(w)) ? 0 : ((a << b) & mask);
      default: return (b >= 32'(w)) ? 0 : (a >> b);
    endcase
  endfunction

  // Cycles spent shifting: the amount clipped at the width, zero for AND/OR.
  function automatic int shift_cycles(input int w, input int unsigned op, input int unsigned b);
    if (op == 0 || op == 2) return 0;
    return (b >= 32'(w)) ? w : int'(b);
  endfunction

  task automatic set_iv(input bit v);
    if (sel4) iv4 = v;
    else iv8 = v;
  endtask

  task automatic set_rdy(input bit v);
    if (sel4) ordy4 = v;
    else ordy8 = v;
  endtask

  task automatic garble();
    op_r = 2'($urandom);
    a_r  = 8'($urandom);
    b_r  = 8'($urandom);
    set_iv(1'($urandom));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered just after a negedge with the selected DUT idle; leaves it idle at a negedge.
  task automatic do_op(input bit s4, input int unsigned op, input int unsigned a, input int unsigned b,
                       input int stall, input bit rdy_early);
    int w, nsh, cyc, busy_seen;
    int unsigned exp, held;
    sel4 = s4;
    w    = s4 ? 4 : 8;
    exp  = golden(w, op, a, b);
    nsh  = shift_cycles(w, op, b);
    chk("in_ready_idle", o_ir(), 1);
    op_r = 2'(op);
    a_r  = 8'(a);
    b_r  = 8'(b);
    set_iv(1'b1);
    set_rdy(rdy_early);
    tick();
    cyc = 1;
    busy_seen = 0;
    while (o_ov() == 0 && cyc < 3 * w + 8) begin
      busy_seen += int'(o_bz());
      garble();
      tick();
      cyc++;
    end
    // One accept cycle plus one cycle per single-bit shift.
    chk("latency", 32'(cyc), 32'(nsh + 1));
    chk("busy_cycles", 32'(busy_seen), 32'(nsh));
    chk("result", o_d(), exp);
    chk("in_ready_done", o_ir(), 0);
    if (!rdy_early) begin
      held = o_d();
      for (int i = 0; i < stall; i++) begin
        garble();
        tick();
        chk("stall_valid", o_ov(), 1);
        chk("stall_d", o_d(), held);
      end
      garble();
      set_rdy(1'b1);
    end
    tick();
    chk("released_valid", o_ov(), 0);
    chk("released_ready", o_ir(), 1);
    set_iv(1'b0);
    set_rdy(1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int ov_seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready8", 32'(ir8), 1);
    chk("rst_valid8", 32'(ov8), 0);
    chk("rst_busy8", 32'(bz8), 0);
    chk("rst_d8", 32'(d8), 0);
    chk("rst_ready4", 32'(ir4), 1);
    chk("rst_d4", 32'(d4), 0);

    do_op(0, 0, 'hF0, 'h3C, 0, 1);
    do_op(0, 2, 'hF0, 'h3C, 0, 1);
    do_op(0, 1, 'h81, 3, 0, 1);
    do_op(0, 3, 'h81, 0, 0, 1);
    do_op(0, 3, 'hFF, 200, 2, 0);
    do_op(0, 1, 'hFF, 8, 1, 0);
    do_op(0, 2, 'h0F, 'h30, 10, 0);
    chk("spot_and", golden(8, 0, 'hF0, 'h3C), 'h30);
    chk("spot_shl", golden(8, 1, 'h81, 3), 'h08);

    // Reset during the third shift cycle discards the operation entirely.
    sel4 = 1'b0;
    op_r = 2'b01; a_r = 8'h01; b_r = 8'd5; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick();
    tick();
    chk("mid_busy", 32'(bz8), 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_ready", 32'(ir8), 1);
    chk("mid_rst_valid", 32'(ov8), 0);
    chk("mid_rst_busy", 32'(bz8), 0);
    chk("mid_rst_d", 32'(d8), 0);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      ov_seen += int'(ov8);
    end
    chk("mid_no_result", 32'(ov_seen), 0);

    for (int i = 0; i < 300; i++) begin
      int unsigned rop, ra, rb;
      int st;
      rop = $urandom_range(0, 3);
      ra  = $urandom_range(0, 255);
      rb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
      st  = $urandom_range(0, 4);
      do_op(0, rop, ra, rb, st, st == 0);
    end

    for (int o = 0; o < 4; o++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          int st;
          st = $urandom_range(0, 2);
          do_op(1, 32'(o), 32'(x), 32'(y), st, st == 0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
